// File: rtl/rect_compositor.sv
// rtl/rect_compositor.sv - rectangle compositor with double-buffered channel registers
//
// Composites up to N_RECT solid rectangles over a black background.
// Each channel has a shadow register set, written at any time. It also has an
// active register set, loaded from the shadow on i_frame_end, and the display
// path only ever reads the active set. Colour comes from the lowest-index
// channel whose rectangle strictly contains the pixel.
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_pix_stb                        pixel strobe; the pipeline advances only when high
//   i_x[9:0], i_y[8:0]               pixel position from the timing generator
//   i_frame_end                      commit pulse: shadow -> active
//   i_wr_en, i_wr_idx[2:0]           shadow write strobe and channel index
//   i_wr_x1/x2/y1/y2[COORD_W-1:0]    rectangle bounds (exclusive)
//   i_wr_rgb[R_W+G_W+B_W-1:0]        channel colour {r,g,b}
//   i_wr_vis                         channel visible
//   o_r, o_g, o_b                    composited colour, 2 strobes after i_x/i_y
//   o_hit[N_RECT-1:0]                per-channel hit mask aligned with the colour
//   o_pending                        shadow holds uncommitted writes
//   o_collision                      previous frame had an overlapping pixel
//
// Build option: define RECT_COLLISION_EN to enable overlap tracking;
// otherwise o_collision is constant 0.

module rect_compositor #(
    parameter int N_RECT  = 3,
    parameter int COORD_W = 12,
    parameter int R_W     = 2,
    parameter int G_W     = 3,
    parameter int B_W     = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pix_stb,
    input  logic [9:0]               i_x,
    input  logic [8:0]               i_y,
    input  logic                     i_frame_end,
    input  logic                     i_wr_en,
    input  logic [2:0]               i_wr_idx,
    input  logic [COORD_W-1:0]       i_wr_x1,
    input  logic [COORD_W-1:0]       i_wr_x2,
    input  logic [COORD_W-1:0]       i_wr_y1,
    input  logic [COORD_W-1:0]       i_wr_y2,
    input  logic [R_W+G_W+B_W-1:0]   i_wr_rgb,
    input  logic                     i_wr_vis,
    output logic [R_W-1:0]           o_r,
    output logic [G_W-1:0]           o_g,
    output logic [B_W-1:0]           o_b,
    output logic [N_RECT-1:0]        o_hit,
    output logic                     o_pending,
    output logic                     o_collision
);

    localparam int RGB_W = R_W + G_W + B_W;
    // Pixel coordinates and bounds are compared at a common width so that a
    // narrow COORD_W never truncates the pixel position.
    localparam int CMP_W = (COORD_W > 10) ? COORD_W : 10;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
        logic [RGB_W-1:0]   rgb;
        logic               vis;
    } rect_t;

    rect_t             shadow_q [N_RECT];
    rect_t             shadow_d [N_RECT];
    rect_t             active_q [N_RECT];
    rect_t             wr_rect;
    logic              wr_valid;
    logic [CMP_W-1:0]  x_c;
    logic [CMP_W-1:0]  y_c;
    logic [N_RECT-1:0] hit_d;
    logic [N_RECT-1:0] hit_s1;
    logic [RGB_W-1:0]  pix_rgb;

    assign wr_valid = i_wr_en && ({1'b0, i_wr_idx} < 4'(N_RECT));
    assign wr_rect  = {i_wr_x1, i_wr_x2, i_wr_y1, i_wr_y2, i_wr_rgb, i_wr_vis};

    // Shadow contents after this cycle's write. The commit copies from this
    // rather than from shadow_q, so a write coincident with i_frame_end is
    // committed with its new value.
    always_comb begin
        for (int i = 0; i < N_RECT; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_valid && (i_wr_idx == 3'(i))) begin
                shadow_d[i] = wr_rect;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_RECT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            o_pending <= 1'b0;
        end else begin
            for (int i = 0; i < N_RECT; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (i_frame_end) begin
                    active_q[i] <= shadow_d[i];
                end
            end
            // The commit takes priority, so a coincident write never leaves
            // pending set.
            if (i_frame_end) begin
                o_pending <= 1'b0;
            end else if (wr_valid) begin
                o_pending <= 1'b1;
            end
        end
    end

    assign x_c = CMP_W'(i_x);
    assign y_c = CMP_W'(i_y);

    // Strict bounds: degenerate rectangles (x2 <= x1+1 or y2 <= y1+1) have
    // no interior pixel and so never hit, with no extra logic.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < N_RECT; i++) begin
            hit_d[i] = active_q[i].vis
                     && (x_c > CMP_W'(active_q[i].x1))
                     && (x_c < CMP_W'(active_q[i].x2))
                     && (y_c > CMP_W'(active_q[i].y1))
                     && (y_c < CMP_W'(active_q[i].y2));
        end
    end

    // Priority select: scan from the top so the lowest-index hit is written last.
    always_comb begin
        pix_rgb = '0;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (hit_s1[i]) begin
                pix_rgb = active_q[i].rgb;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hit_s1 <= '0;
            o_hit  <= '0;
            o_r    <= '0;
            o_g    <= '0;
            o_b    <= '0;
        end else if (i_pix_stb) begin
            hit_s1 <= hit_d;
            o_hit  <= hit_s1;
            o_r    <= pix_rgb[RGB_W-1 -: R_W];
            o_g    <= pix_rgb[G_W+B_W-1 -: G_W];
            o_b    <= pix_rgb[B_W-1:0];
        end
    end

`ifdef RECT_COLLISION_EN
    logic sticky_q;
    logic overlap_now;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign overlap_now = i_pix_stb && ((hit_s1 & (hit_s1 - N_RECT'(1))) != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sticky_q    <= 1'b0;
            o_collision <= 1'b0;
        end else if (i_frame_end) begin
            o_collision <= sticky_q | overlap_now;
            sticky_q    <= 1'b0;
        end else if (overlap_now) begin
            sticky_q    <= 1'b1;
        end
    end
`else
    assign o_collision = 1'b0;
`endif

endmodule

// File: tb/tb_rect_compositor.sv
// tb/tb_rect_compositor.sv - self-checking bench for rect_compositor

module tb_rect_compositor;

    localparam int N  = 3;
    localparam int CW = 12;
`ifdef RECT_COLLISION_EN
    localparam int COLL_EN = 1;
`else
    localparam int COLL_EN = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_pix_stb;
    logic [9:0]    i_x;
    logic [8:0]    i_y;
    logic          i_frame_end;
    logic          i_wr_en;
    logic [2:0]    i_wr_idx;
    logic [CW-1:0] i_wr_x1, i_wr_x2, i_wr_y1, i_wr_y2;
    logic [7:0]    i_wr_rgb;
    logic          i_wr_vis;
    logic [1:0]    o_r;
    logic [2:0]    o_g;
    logic [2:0]    o_b;
    logic [N-1:0]  o_hit;
    logic          o_pending;
    logic          o_collision;

    always #5 i_clk = ~i_clk;

    rect_compositor #(.N_RECT(N), .COORD_W(CW), .R_W(2), .G_W(3), .B_W(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .i_x(i_x), .i_y(i_y), .i_frame_end(i_frame_end),
        .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx),
        .i_wr_x1(i_wr_x1), .i_wr_x2(i_wr_x2), .i_wr_y1(i_wr_y1), .i_wr_y2(i_wr_y2),
        .i_wr_rgb(i_wr_rgb), .i_wr_vis(i_wr_vis),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_hit(o_hit),
        .o_pending(o_pending), .o_collision(o_collision)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rectangles as plain integers, pixel history as "mask of
    // the previously strobed pixel" and "what was shown last".
    typedef struct {
        int x1; int x2; int y1; int y2; int rgb; int vis;
    } mrect_t;

    mrect_t m_sh [N];
    mrect_t m_act[N];
    int     m_prev_mask, m_new_mask, m_hit, m_col, m_pend, m_coll, m_sticky;
    bit     m_ovl;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < N; c++) begin
                m_sh[c]  = '{0, 0, 0, 0, 0, 0};
                m_act[c] = '{0, 0, 0, 0, 0, 0};
            end
            m_prev_mask = 0; m_hit = 0; m_col = 0; m_pend = 0; m_coll = 0; m_sticky = 0;
        end else begin
            m_ovl = 0;
            if (i_pix_stb) begin
                m_new_mask = 0;
                for (int c = 0; c < N; c++) begin
                    if (m_act[c].vis != 0 &&
                        int'(i_x) > m_act[c].x1 && int'(i_x) < m_act[c].x2 &&
                        int'(i_y) > m_act[c].y1 && int'(i_y) < m_act[c].y2)
                        m_new_mask = m_new_mask + (1 << c);
                end
                m_col = 0;
                for (int c = 0; c < N; c++) begin
                    if (m_col == 0 && m_hit_bit(m_prev_mask, c)) m_col = m_act[c].rgb | 32'h100;
                end
                m_col = m_col & 8'hFF;
                m_ovl = $countones(m_prev_mask) >= 2;
                m_hit = m_prev_mask;
                m_prev_mask = m_new_mask;
            end
            if (i_frame_end) begin
                m_coll   = (m_sticky != 0 || m_ovl) ? 1 : 0;
                m_sticky = 0;
            end else if (m_ovl) begin
                m_sticky = 1;
            end
            if (i_wr_en && int'(i_wr_idx) < N)
                m_sh[i_wr_idx] = '{int'(i_wr_x1), int'(i_wr_x2), int'(i_wr_y1), int'(i_wr_y2),
                                   int'(i_wr_rgb), int'(i_wr_vis)};
            if (i_frame_end) begin
                m_act  = m_sh;
                m_pend = 0;
            end else if (i_wr_en && int'(i_wr_idx) < N) begin
                m_pend = 1;
            end
        end
    end

    function automatic bit m_hit_bit(input int mask, input int c);
        return ((mask >> c) & 1) == 1;
    endfunction

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("cmp_r",   o_r,   (m_col >> 6) & 3);
            check("cmp_g",   o_g,   (m_col >> 3) & 7);
            check("cmp_b",   o_b,   m_col & 7);
            check("cmp_hit", o_hit, m_hit);
            check("cmp_pending",   o_pending,   m_pend);
            check("cmp_collision", o_collision, COLL_EN ? m_coll : 0);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        i_x = 10'(x); i_y = 9'(y); i_pix_stb = 1'b1;
        tick();
        i_pix_stb = 1'b0;
    endtask

    task automatic wr(input int idx, input int x1, input int x2, input int y1, input int y2,
                      input int rgb, input int vis, input bit fe);
        i_wr_en = 1'b1; i_wr_idx = 3'(idx);
        i_wr_x1 = CW'(x1); i_wr_x2 = CW'(x2); i_wr_y1 = CW'(y1); i_wr_y2 = CW'(y2);
        i_wr_rgb = 8'(rgb); i_wr_vis = vis[0]; i_frame_end = fe;
        tick();
        i_wr_en = 1'b0; i_frame_end = 1'b0;
    endtask

    task automatic frame_end();
        i_frame_end = 1'b1;
        tick();
        i_frame_end = 1'b0;
    endtask

    task automatic check_out(input string name, input int r, input int g, input int b, input int hit);
        check({name, "_r"}, o_r, r);
        check({name, "_g"}, o_g, g);
        check({name, "_b"}, o_b, b);
        check({name, "_hit"}, o_hit, hit);
    endtask

    int xs[4]   = '{100, 101, 199, 200};
    int hexp[4] = '{0, 1, 1, 0};

    initial begin
        i_rst = 1'b0; i_pix_stb = 1'b0; i_x = '0; i_y = '0; i_frame_end = 1'b0;
        i_wr_en = 1'b0; i_wr_idx = '0; i_wr_x1 = '0; i_wr_x2 = '0; i_wr_y1 = '0; i_wr_y2 = '0;
        i_wr_rgb = '0; i_wr_vis = 1'b0;
        #2 i_rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        check_out("reset", 0, 0, 0, 0);
        check("reset_pending", o_pending, 0);
        check("reset_collision", o_collision, 0);

        // Shadow write is invisible until committed.
        wr(0, 160, 220, 120, 180, 8'hFF, 1, 0);
        check("shadow_pending", o_pending, 1);
        pix(190, 150); pix(190, 150);
        check_out("shadow_black", 0, 0, 0, 0);
        frame_end();
        check("commit_pending", o_pending, 0);
        pix(190, 150); pix(0, 0);
        check_out("commit_white", 3, 7, 7, 1);

        // Strict x bounds, written together with the commit.
        wr(0, 100, 200, 100, 200, 8'hFF, 1, 1);
        check("coinc_pending", o_pending, 0);
        for (int k = 0; k < 4; k++) begin
            pix(xs[k], 150); pix(0, 0);
            check($sformatf("edge_x%0d", xs[k]), o_hit[0], hexp[k]);
        end
        pix(150, 100); pix(0, 0);
        check("edge_y100", o_hit[0], 0);
        pix(150, 101); pix(0, 0);
        check("edge_y101", o_hit[0], 1);

        // Overlap: lower index wins, collision reported after the frame.
        wr(0, 100, 200, 100, 200, 8'hC0, 1, 0);
        wr(1, 140, 160, 140, 160, 8'h38, 1, 1);
        pix(150, 150); pix(150, 150);
        check_out("overlap", 3, 0, 0, 3);
        pix(0, 0); pix(0, 0);
        frame_end();
        check("collision_set", o_collision, COLL_EN);
        pix(10, 10); pix(10, 10); pix(10, 10);
        frame_end();
        check("collision_clear", o_collision, 0);

        // Write coincident with commit, and an out-of-range index.
        wr(2, 0, 50, 0, 50, 8'h07, 1, 1);
        check("ch2_pending", o_pending, 0);
        pix(20, 20); pix(0, 0);
        check_out("ch2_blue", 0, 0, 7, 4);
        wr(5, 0, 1000, 0, 500, 8'hFF, 1, 0);
        check("idx5_pending", o_pending, 0);
        frame_end();
        pix(20, 20); pix(0, 0);
        check_out("idx5_nochange", 0, 0, 7, 4);

        // Strobe low holds the pipeline.
        pix(20, 20); pix(20, 20);
        for (int k = 0; k < 10; k++) begin
            i_x = 10'($urandom_range(0, 1023));
            i_y = 9'($urandom_range(0, 40));
            tick();
            check_out("hold", 0, 0, 7, 4);
        end

        // Asynchronous reset mid-cycle.
        i_pix_stb = 1'b1;
        @(posedge i_clk);
        #3 i_rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        check("async_rst_pending", o_pending, 0);
        check("async_rst_collision", o_collision, 0);
        i_pix_stb = 1'b0;
        tick();
        i_rst = 1'b0;

        // Randomised traffic; the compare process checks every cycle.
        repeat (3000) begin
            i_pix_stb   = ($urandom_range(0, 3) != 0);
            i_x         = 10'($urandom_range(0, 70));
            i_y         = 9'($urandom_range(0, 70));
            i_wr_en     = ($urandom_range(0, 3) == 0);
            i_wr_idx    = 3'($urandom_range(0, 7));
            i_wr_x1     = CW'($urandom_range(0, 64));
            i_wr_x2     = CW'($urandom_range(0, 64));
            i_wr_y1     = CW'($urandom_range(0, 64));
            i_wr_y2     = CW'($urandom_range(0, 64));
            i_wr_rgb    = 8'($urandom_range(0, 255));
            i_wr_vis    = ($urandom_range(0, 3) != 0);
            i_frame_end = ($urandom_range(0, 39) == 0);
            tick();
        end
        i_pix_stb = 1'b0; i_wr_en = 1'b0; i_frame_end = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rect_compositor.md
RECT_COMPOSITOR -- requirements
Module: rect_compositor

Interface
REQ-001 Parameter N_RECT, default 3: number of rectangle channels, 1..8.
REQ-002 Parameter COORD_W, default 12: rectangle coordinate width in bits.
REQ-003 Parameter R_W, default 2; G_W, default 3; B_W, default 3: colour channel widths.
REQ-004 i_clk  input  1: system clock; all state updates on its rising edge.
REQ-005 i_rst  input  1: asynchronous, active-high reset.
REQ-006 i_pix_stb  input  1: pixel strobe; the pipeline advances only when high.
REQ-007 i_x  input  10, i_y  input  9: current pixel position from the timing generator.
REQ-008 i_frame_end  input  1: single-cycle pulse at end of drawing (animate); commit point.
REQ-009 i_wr_en  input  1: shadow-register write strobe.
REQ-010 i_wr_idx  input  3: channel index for the write.
REQ-011 i_wr_x1, i_wr_x2, i_wr_y1, i_wr_y2  input  COORD_W each: rectangle bounds.
REQ-012 i_wr_rgb  input  R_W+G_W+B_W: channel colour, packed {r,g,b}; i_wr_vis  input  1: channel visible.
REQ-013 o_r  output  R_W, o_g  output  G_W, o_b  output  B_W: composited pixel colour.
REQ-014 o_hit  output  N_RECT: registered per-channel hit mask aligned with the colour outputs.
REQ-015 o_pending  output  1: shadow holds writes not yet committed.
REQ-016 o_collision  output  1: previous frame contained at least one overlapping pixel.

Function
REQ-017 Each channel SHALL hold a shadow set {x1,x2,y1,y2,rgb,vis} and an active set of the same fields.
REQ-018 i_wr_en with i_wr_idx < N_RECT SHALL write the shadow set of that channel in the same cycle; i_wr_idx >= N_RECT SHALL be ignored, with no effect on o_pending.
REQ-019 i_frame_end SHALL copy every shadow set to its active set; the display never uses shadow values directly.
REQ-020 i_wr_en coincident with i_frame_end SHALL be committed in that same cycle, using the newly written value.
REQ-021 o_pending SHALL set on the cycle after a valid write, and clear on the cycle after i_frame_end; a coincident write leaves it clear.
REQ-022 Channel hit SHALL be vis & (x > x1) & (x < x2) & (y > y1) & (y < y2): strict bounds, with i_x and i_y zero-extended to COORD_W, unsigned compare.
REQ-023 Stage 1, on i_pix_stb: register the hit mask computed from the active sets.
REQ-024 Stage 2, on i_pix_stb: register the colour of the lowest-index hit channel into o_r/o_g/o_b, and register the stage-1 mask into o_hit; no hit gives all-zero colour.
REQ-025 Latency SHALL be exactly 2 strobes from i_x/i_y to the outputs; all pipeline registers SHALL hold while i_pix_stb is low.
REQ-026 A rectangle with x2 <= x1+1 or y2 <= y1+1 SHALL never hit.
REQ-027 An internal sticky flag SHALL set on any strobe where the stage-1 mask has two or more bits set.
REQ-028 On i_frame_end, o_collision SHALL load the sticky flag OR'd with the current-strobe overlap, and the sticky flag SHALL clear.

Reset
REQ-029 i_rst SHALL asynchronously clear all shadow and active sets (vis=0), both pipeline stages, o_r/o_g/o_b, o_hit, o_pending, o_collision and the sticky flag.
REQ-030 After reset release the output SHALL be black until a write is committed and 2 further strobes have elapsed.

Configuration
REQ-031 Macro RECT_COLLISION_EN defined: REQ-027 and REQ-028 are implemented.
REQ-032 Macro RECT_COLLISION_EN undefined: the sticky flag logic is absent and o_collision is tied to 0.

Verification
REQ-033 Write ch0 {160,220,120,180,rgb=all-ones,vis=1}, no frame_end -> outputs stay 0, o_pending=1; pulse frame_end -> o_pending=0, and pixel (190,150) shows ch0 colour 2 strobes later.
REQ-034 Committed ch0 {100,200,100,200}: pixel x=100 -> o_hit[0]=0; x=101 -> 1; x=199 -> 1; x=200 -> 0 (y=150).
REQ-035 ch0 red and ch1 green, both covering (150,150) -> colour = red, o_hit=2'b11; a collision-enabled build sets o_collision=1 after next frame_end, and it drops to 0 after a frame with no overlap.
REQ-036 Write ch2 in the same cycle as frame_end -> change visible in next frame; o_pending stays 0. Write with idx=5 (N_RECT=3) -> no change, o_pending=0.
REQ-037 Hold i_pix_stb low for 10 cycles while i_x changes -> outputs unchanged; assert i_rst mid-frame -> all outputs 0 immediately, without a clock edge.
